// File: rtl/dmac_ctrl_slave.sv
// dmac_ctrl_slave: AXI4-Lite control responder holding DMA length/addresses and the ap_start/ap_done handshake
// Ports:
//   ap_clk, ap_rstn                 clock, asynchronous active-low reset
//   s_axi_control_aw*/w*/b*         AXI4-Lite write channels (bresp always OKAY)
//   s_axi_control_ar*/r*            AXI4-Lite read channels (rresp always OKAY)
//   ap_start                        one-cycle start pulse to the engine
//   ap_done, ap_idle                completion pulse and idle level from the engine
//   byte_len, src_addr, dst_addr    static transfer configuration
//   interrupt                       level interrupt, only live when DMAC_CTRL_IRQ_EN is defined
// Optional feature: `define DMAC_CTRL_IRQ_EN adds GIE/IER/ISR at 0x04/0x08/0x0C and drives interrupt.
module dmac_ctrl_slave #(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH         = 32
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rstn,
    input  logic                                    s_axi_control_awvalid,
    output logic                                    s_axi_control_awready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                                    s_axi_control_wvalid,
    output logic                                    s_axi_control_wready,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                                    s_axi_control_bvalid,
    input  logic                                    s_axi_control_bready,
    output logic [1:0]                              s_axi_control_bresp,
    input  logic                                    s_axi_control_arvalid,
    output logic                                    s_axi_control_arready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                                    s_axi_control_rvalid,
    input  logic                                    s_axi_control_rready,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                              s_axi_control_rresp,
    output logic                                    ap_start,
    input  logic                                    ap_done,
    input  logic                                    ap_idle,
    output logic [31:0]                             byte_len,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           src_addr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           dst_addr,
    output logic                                    interrupt
);
    localparam int DW = C_S_AXI_CONTROL_DATA_WIDTH;
    localparam int AW = C_S_AXI_CONTROL_ADDR_WIDTH;

    logic          live;
    logic          aw_held, w_held;
    logic [3:0]    aw_off;
    logic [DW-1:0] wd_q;
    logic [DW/8-1:0] ws_q;
    logic          busy, done;
    logic [DW-1:0] len_q, src_q, dst_q;
    logic [DW-1:0] rd_val;
    logic          commit, wr_cfg, start, ar_hs, ctrl_rd;
    logic          unused_ok;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [DW/8-1:0] s);
        merge = old;
        for (int i = 0; i < DW/8; i++)
            if (s[i]) merge[8*i +: 8] = d[8*i +: 8];
    endfunction

    // live keeps every ready low while reset is asserted
    assign s_axi_control_awready = live & ~aw_held;
    assign s_axi_control_wready  = live & ~w_held;
    assign s_axi_control_arready = live & ~s_axi_control_rvalid;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_rresp   = 2'b00;
    assign commit  = aw_held & w_held & ~s_axi_control_bvalid;
    assign wr_cfg  = commit & ~busy;
    assign start   = wr_cfg & (aw_off == 4'h4) & ws_q[0] & wd_q[0];
    assign ar_hs   = s_axi_control_arvalid & s_axi_control_arready;
    assign ctrl_rd = ar_hs & (s_axi_control_araddr[5:2] == 4'h4);
    assign byte_len = len_q;
    assign src_addr = src_q[C_M_AXI_ADDR_WIDTH-1:0];
    assign dst_addr = dst_q[C_M_AXI_ADDR_WIDTH-1:0];
    assign unused_ok = ^{s_axi_control_awaddr[AW-1:6], s_axi_control_awaddr[1:0],
                         s_axi_control_araddr[AW-1:6], s_axi_control_araddr[1:0]};

`ifdef DMAC_CTRL_IRQ_EN
    logic gie, ier, isr;
    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            gie       <= 1'b0;
            ier       <= 1'b0;
            isr       <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (commit && aw_off == 4'h1 && ws_q[0]) gie <= wd_q[0];
            if (commit && aw_off == 4'h2 && ws_q[0]) ier <= wd_q[0];
            // toggle on write-1, but a completion in the same cycle always leaves it set
            isr       <= (isr ^ (commit & (aw_off == 4'h3) & ws_q[0] & wd_q[0])) | (ap_done & ier);
            interrupt <= gie & isr;
        end
    end
`else
    assign interrupt = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (s_axi_control_araddr[5:2])
`ifdef DMAC_CTRL_IRQ_EN
            4'h1: rd_val = {{(DW-1){1'b0}}, gie};
            4'h2: rd_val = {{(DW-1){1'b0}}, ier};
            4'h3: rd_val = {{(DW-1){1'b0}}, isr};
`endif
            4'h4: rd_val = {{(DW-4){1'b0}}, ~busy, ap_idle, done, busy};
            4'h5: rd_val = len_q;
            4'h6: rd_val = src_q;
            4'h7: rd_val = dst_q;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            live                 <= 1'b0;
            aw_held              <= 1'b0;
            aw_off               <= '0;
            w_held               <= 1'b0;
            wd_q                 <= '0;
            ws_q                 <= '0;
            s_axi_control_bvalid <= 1'b0;
        end else begin
            live <= 1'b1;
            if (s_axi_control_awvalid && s_axi_control_awready) begin
                aw_held <= 1'b1;
                aw_off  <= s_axi_control_awaddr[5:2];
            end
            if (s_axi_control_wvalid && s_axi_control_wready) begin
                w_held <= 1'b1;
                wd_q   <= s_axi_control_wdata;
                ws_q   <= s_axi_control_wstrb;
            end
            if (commit) s_axi_control_bvalid <= 1'b1;
            if (s_axi_control_bvalid && s_axi_control_bready) begin
                s_axi_control_bvalid <= 1'b0;
                aw_held              <= 1'b0;
                w_held               <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            s_axi_control_rvalid <= 1'b0;
            s_axi_control_rdata  <= '0;
        end else begin
            if (ar_hs) begin
                s_axi_control_rvalid <= 1'b1;
                s_axi_control_rdata  <= rd_val;
            end else if (s_axi_control_rready) begin
                s_axi_control_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            ap_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            len_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
        end else begin
            ap_start <= start;
            busy     <= start | (busy & ~ap_done);
            // completion beats a simultaneous clear-on-read
            done     <= ap_done | (done & ~ctrl_rd);
            if (wr_cfg && aw_off == 4'h5) len_q <= merge(len_q, wd_q, ws_q);
            if (wr_cfg && aw_off == 4'h6) src_q <= merge(src_q, wd_q, ws_q);
            if (wr_cfg && aw_off == 4'h7) dst_q <= merge(dst_q, wd_q, ws_q);
        end
    end
endmodule

// File: tb/tb_dmac_ctrl_slave.sv
// tb_dmac_ctrl_slave: directed self-checking bench for dmac_ctrl_slave
module tb_dmac_ctrl_slave;
    logic        ap_clk = 1'b0;
    logic        ap_rstn = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [11:0] awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp, rresp;
    logic        arvalid = 1'b0, arready;
    logic [11:0] araddr = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic        ap_start, ap_done = 1'b0, ap_idle = 1'b1;
    logic [31:0] byte_len, src_addr, dst_addr;
    logic        interrupt;
    int          checks = 0, errors = 0, starts = 0;
    logic [31:0] v;

    always #5 ap_clk = ~ap_clk;

    always @(negedge ap_clk) if (ap_start) starts++;

    dmac_ctrl_slave dut (
        .ap_clk(ap_clk), .ap_rstn(ap_rstn),
        .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready), .s_axi_control_awaddr(awaddr),
        .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
        .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
        .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready), .s_axi_control_bresp(bresp),
        .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready), .s_axi_control_araddr(araddr),
        .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
        .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .byte_len(byte_len), .src_addr(src_addr), .dst_addr(dst_addr), .interrupt(interrupt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int   n;
        logic ah, wh;
        n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            ah = awready;
            wh = wready;
            tick(1);
            n++;
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
        end
        chk("aw_w_timeout", 32'(n >= 20), 0);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick(1);
            n++;
        end
        chk("bvalid", {31'b0, bvalid}, 1);
        chk("bresp", {30'b0, bresp}, 0);
        tick(1);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            tick(1);
            n++;
        end
        chk("ar_timeout", 32'(n >= 20), 0);
        tick(1);
        arvalid = 1'b0;
        chk("rvalid", {31'b0, rvalid}, 1);
        chk("rresp", {30'b0, rresp}, 0);
        d = rdata;
        tick(1);
        rready = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic done_pulse();
        ap_done = 1'b1;
        tick(1);
        ap_done = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_bvalid", {31'b0, bvalid}, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_awready", {31'b0, awready}, 0);
        chk("rst_arready", {31'b0, arready}, 0);
        chk("rst_ap_start", {31'b0, ap_start}, 0);
        chk("rst_rdata", rdata, 0);
        #3 ap_rstn = 1'b1;
        tick(2);
        rdchk("ctrl_reset", 12'h010, 32'h0000_000C);

        wr(12'h014, 32'd4096, 4'hF);
        wr(12'h018, 32'h1000_0000, 4'hF);
        wr(12'h01C, 32'h2000_0000, 4'hF);
        chk("byte_len", byte_len, 32'd4096);
        chk("src_addr", src_addr, 32'h1000_0000);
        chk("dst_addr", dst_addr, 32'h2000_0000);
        rdchk("rd_len", 12'h014, 32'd4096);
        rdchk("rd_src", 12'h018, 32'h1000_0000);
        rdchk("rd_dst", 12'h01C, 32'h2000_0000);

        wr(12'h014, 32'hAABB_CCDD, 4'b0101);
        chk("strobe_merge", byte_len, 32'h00BB_10DD);
        wr(12'h014, 32'd4096, 4'hF);

        wr(12'h020, 32'hFFFF_FFFF, 4'hF);
        rdchk("unmapped_rd", 12'h020, 0);
        chk("unmapped_len", byte_len, 32'd4096);

        wr(12'h010, 32'h1, 4'hF);
        tick(2);
        chk("start_once", starts, 1);
        ap_idle = 1'b0;
        rdchk("ctrl_busy", 12'h010, 32'h1);
        wr(12'h010, 32'h1, 4'hF);
        tick(2);
        chk("start_while_busy", starts, 1);
        wr(12'h014, 32'd5, 4'hF);
        chk("len_locked", byte_len, 32'd4096);

        ap_idle = 1'b1;
        done_pulse();
        rdchk("ctrl_done", 12'h010, 32'h0000_000E);
        rdchk("ctrl_cor", 12'h010, 32'h0000_000C);

        araddr = 12'h010; arvalid = 1'b1; rready = 1'b0; ap_done = 1'b1;
        tick(1);
        ap_done = 1'b0; arvalid = 1'b0;
        chk("done_race_rdata", rdata, 32'h0000_000C);
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        rdchk("done_race_set", 12'h010, 32'h0000_000E);
        rdchk("done_race_clr", 12'h010, 32'h0000_000C);

        bready = 1'b0; awaddr = 12'h018; wdata = 32'h0000_1234; wstrb = 4'hF; wvalid = 1'b1;
        tick(1);
        chk("w_first_wready", {31'b0, wready}, 0);
        wvalid = 1'b0;
        tick(2);
        awvalid = 1'b1;
        tick(1);
        awvalid = 1'b0;
        tick(1);
        awaddr = 12'h01C; wdata = 32'hDEAD_BEEF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bvalid_hold", {31'b0, bvalid}, 1);
            chk("no_second_aw", {31'b0, awready}, 0);
            tick(1);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("single_commit_src", src_addr, 32'h0000_1234);
        chk("single_commit_dst", dst_addr, 32'h2000_0000);
        bready = 1'b1;
        tick(1);
        chk("b_release", {31'b0, bvalid}, 0);
        chk("aw_reopen", {31'b0, awready}, 1);

        awaddr = 12'h014; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0; araddr = 12'h014; arvalid = 1'b1;
        tick(1);
        arvalid = 1'b0;
        chk("rw_same_rdata", rdata, 32'd4096);
        chk("rw_same_len", byte_len, 32'h77);
        rready = 1'b1;
        tick(1);
        rready = 1'b0;

`ifdef DMAC_CTRL_IRQ_EN
        wr(12'h004, 32'h1, 4'hF);
        wr(12'h008, 32'h1, 4'hF);
        done_pulse();
        tick(2);
        chk("irq_set", {31'b0, interrupt}, 1);
        rdchk("isr_rd", 12'h00C, 32'h1);
        wr(12'h00C, 32'h1, 4'hF);
        tick(2);
        chk("irq_clr", {31'b0, interrupt}, 0);
`else
        wr(12'h004, 32'h1, 4'hF);
        done_pulse();
        tick(2);
        chk("irq_off", {31'b0, interrupt}, 0);
        rdchk("gie_unmapped", 12'h004, 0);
`endif

        araddr = 12'h014; arvalid = 1'b1; rready = 1'b0;
        tick(1);
        arvalid = 1'b0;
        chk("pre_rst_rvalid", {31'b0, rvalid}, 1);
        #2 ap_rstn = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'b0, rvalid}, 0);
        chk("mid_rst_arready", {31'b0, arready}, 0);
        chk("mid_rst_len", byte_len, 0);
        chk("mid_rst_src", src_addr, 0);
        #4 ap_rstn = 1'b1;
        tick(2);
        chk("post_rst_awready", {31'b0, awready}, 1);
        rdchk("post_rst_ctrl", 12'h010, 32'h0000_000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
